// File: rtl/regfile_pkg.sv
// Shared types and constants for the register-file write-back arbiter.
// Latency: none (declarations only).
// Backpressure: not applicable.
package regfile_pkg;

  localparam int NUM_REGS = 32;

  typedef logic [4:0]  reg_addr_t;
  typedef logic [31:0] word_t;

  // Identifies which producer owns the write port.
  typedef enum logic {
    WB_EXEC = 1'b0,
    WB_LONG = 1'b1
  } wb_src_e;

  // One write-port transaction.
  typedef struct packed {
    reg_addr_t addr;
    word_t     data;
  } wb_req_t;

endpackage

// File: rtl/wb_grant_logic.sv
// Grants the single register-file write port to one of two producers.
// Latency: ready is combinational from the valids and current state; state updates on posedge.
// Backpressure: the loser sees ready low; WB_RR_EN selects round-robin instead of priority+starvation.
module wb_grant_logic
  import regfile_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic wb0_valid,
  input  logic wb1_valid,
  output logic wb0_ready,
  output logic wb1_ready
);

`ifdef WB_RR_EN
  // Remembers who won last; the other side wins the next contended cycle.
  wb_src_e last_grant;

  // Alternate on contention; a lone requester is always granted.
  always_comb begin
    wb0_ready = reset && wb0_valid && (!wb1_valid || (last_grant == WB_LONG));
    wb1_ready = reset && wb1_valid && (!wb0_valid || (last_grant == WB_EXEC));
  end

  // Record the source of each completed transfer.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      last_grant <= WB_LONG;
    end else if (wb0_valid && wb0_ready) begin
      last_grant <= WB_EXEC;
    end else if (wb1_valid && wb1_ready) begin
      last_grant <= WB_LONG;
    end
  end
`else
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  logic [CNT_W-1:0] starve_cnt;
  logic             starved;

  assign starved = (starve_cnt == CNT_W'(STARVE_LIMIT));

  // Execute path wins unless the long-latency unit has waited too long.
  always_comb begin
    wb0_ready = reset && wb0_valid && !(starved && wb1_valid);
    wb1_ready = reset && wb1_valid && (starved || !wb0_valid);
  end

  // Count refused requester-1 cycles, saturating; any requester-1 transfer restarts it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      starve_cnt <= '0;
    end else if (wb1_valid && wb1_ready) begin
      starve_cnt <= '0;
    end else if (wb1_valid && !starved) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-port arbiter and pending-write scoreboard for the 32x32 register file (option WB_RR_EN: round-robin grant).
// Latency: handshake at posedge N drives reg_wr/waddr/wdata from N to N+1; busy updates at N.
// Backpressure: wb0/wb1 valid-ready with one grant per cycle; alloc_ready low while the target is still pending.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        wb0_valid,
  input  logic [4:0]  wb0_addr,
  input  logic [31:0] wb0_data,
  output logic        wb0_ready,
  input  logic        wb1_valid,
  input  logic [4:0]  wb1_addr,
  input  logic [31:0] wb1_data,
  output logic        wb1_ready,
  input  logic        alloc_valid,
  input  logic [4:0]  alloc_addr,
  output logic        alloc_ready,
  output logic        reg_wr,
  output logic [4:0]  waddr,
  output logic [31:0] wdata,
  output logic [31:0] busy
);

  logic                xfer0;
  logic                xfer1;
  wb_req_t             win;
  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_nxt;

  wb_grant_logic #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_grant (
    .clock     (clock),
    .reset     (reset),
    .wb0_valid (wb0_valid),
    .wb1_valid (wb1_valid),
    .wb0_ready (wb0_ready),
    .wb1_ready (wb1_ready)
  );

  // Pick the transferring request; grant logic guarantees at most one.
  always_comb begin
    xfer0 = wb0_valid && wb0_ready;
    xfer1 = wb1_valid && wb1_ready;
    win   = xfer1 ? '{addr: wb1_addr, data: wb1_data}
                  : '{addr: wb0_addr, data: wb0_data};
  end

  // Register the winning write; x0 writes complete the handshake but never enable the file.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      reg_wr <= 1'b0;
      waddr  <= '0;
      wdata  <= '0;
    end else if (xfer0 || xfer1) begin
      reg_wr <= (win.addr != '0);
      waddr  <= win.addr;
      wdata  <= win.data;
    end else begin
      reg_wr <= 1'b0;
    end
  end

  // A reservation may reuse a register whose pending write retires this very cycle.
  always_comb begin
    alloc_ready = !busy_q[alloc_addr] || (xfer1 && (wb1_addr == alloc_addr));
  end

  // Requester-1 completion clears first, then a new reservation sets, so set wins.
  always_comb begin
    busy_nxt = busy_q;
    if (xfer1) begin
      busy_nxt[wb1_addr] = 1'b0;
    end
    if (alloc_valid && alloc_ready && (alloc_addr != '0)) begin
      busy_nxt[alloc_addr] = 1'b1;
    end
  end

  // Pending-write scoreboard state.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_nxt;
    end
  end

  assign busy = busy_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed self-checking bench for regfile_wb_arbiter.
// Latency: inputs change 1 ns after posedge; readys checked 1 ns later, registered outputs 1 ns after the next posedge.
// Backpressure: exercised through contention, starvation and scoreboard scenarios.
module tb_regfile_wb_arbiter;

  logic        clock;
  logic        reset;
  logic        wb0_valid;
  logic [4:0]  wb0_addr;
  logic [31:0] wb0_data;
  logic        wb0_ready;
  logic        wb1_valid;
  logic [4:0]  wb1_addr;
  logic [31:0] wb1_data;
  logic        wb1_ready;
  logic        alloc_valid;
  logic [4:0]  alloc_addr;
  logic        alloc_ready;
  logic        reg_wr;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [31:0] busy;

  int checks = 0;
  int errors = 0;

  regfile_wb_arbiter #(.STARVE_LIMIT(4)) dut (
    .clock       (clock),
    .reset       (reset),
    .wb0_valid   (wb0_valid),
    .wb0_addr    (wb0_addr),
    .wb0_data    (wb0_data),
    .wb0_ready   (wb0_ready),
    .wb1_valid   (wb1_valid),
    .wb1_addr    (wb1_addr),
    .wb1_data    (wb1_data),
    .wb1_ready   (wb1_ready),
    .alloc_valid (alloc_valid),
    .alloc_addr  (alloc_addr),
    .alloc_ready (alloc_ready),
    .reg_wr      (reg_wr),
    .waddr       (waddr),
    .wdata       (wdata),
    .busy        (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance to 1 ns after the next rising edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    wb0_valid   = 1'b0;
    wb0_addr    = '0;
    wb0_data    = '0;
    wb1_valid   = 1'b0;
    wb1_addr    = '0;
    wb1_data    = '0;
    alloc_valid = 1'b0;
    alloc_addr  = '0;
  endtask

  // Clears all state; returns 1 ns after a posedge with reset released.
  task automatic do_reset();
    idle_inputs();
    reset = 1'b0;
    step();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset     = 1'b0;
    idle_inputs();
    wb0_valid = 1'b1; wb0_addr = 5'd3; wb0_data = 32'h0000_0033;
    wb1_valid = 1'b1; wb1_addr = 5'd4; wb1_data = 32'h0000_0044;
    step(); step();
    checks++; if (reg_wr !== 1'b0) begin errors++; $display("FAIL reset_reg_wr got %b want 0", reg_wr); end
    checks++; if (busy !== 32'h0) begin errors++; $display("FAIL reset_busy got %h want 00000000", busy); end
    checks++; if (wb0_ready !== 1'b0) begin errors++; $display("FAIL reset_wb0_ready got %b want 0", wb0_ready); end
    checks++; if (wb1_ready !== 1'b0) begin errors++; $display("FAIL reset_wb1_ready got %b want 0", wb1_ready); end
    checks++; if (waddr !== 5'd0 || wdata !== 32'h0) begin errors++; $display("FAIL reset_wport got %0d/%h want 0/00000000", waddr, wdata); end
    reset = 1'b1;
    #1;
    checks++; if (wb0_ready !== 1'b1 || wb1_ready !== 1'b0) begin errors++; $display("FAIL post_reset_grant got %b%b want 10", wb0_ready, wb1_ready); end
    step();
    checks++; if (reg_wr !== 1'b1 || waddr !== 5'd3 || wdata !== 32'h0000_0033) begin
      errors++; $display("FAIL post_reset_write got %b/%0d/%h want 1/3/00000033", reg_wr, waddr, wdata);
    end
  endtask

  task automatic test_contention();
    do_reset();
    wb0_valid = 1'b1; wb0_addr = 5'd5; wb0_data = 32'hAAAA_0001;
    wb1_valid = 1'b1; wb1_addr = 5'd6; wb1_data = 32'h5555_0002;
    #1;
    checks++; if (wb0_ready !== 1'b1 || wb1_ready !== 1'b0) begin errors++; $display("FAIL contention_grant got %b%b want 10", wb0_ready, wb1_ready); end
    step();
    checks++; if (reg_wr !== 1'b1 || waddr !== 5'd5 || wdata !== 32'hAAAA_0001) begin
      errors++; $display("FAIL contention_write got %b/%0d/%h want 1/5/aaaa0001", reg_wr, waddr, wdata);
    end
  endtask

  task automatic test_starvation();
    logic exp1;
    do_reset();
    wb0_valid = 1'b1; wb0_addr = 5'd1; wb0_data = 32'h1111_1111;
    wb1_valid = 1'b1; wb1_addr = 5'd2; wb1_data = 32'h2222_2222;
    for (int c = 1; c <= 10; c++) begin
      exp1 = (c % 5 == 0);
      #1;
      checks++; if (wb0_ready !== !exp1 || wb1_ready !== exp1) begin
        errors++; $display("FAIL starve_grant cycle %0d got %b%b want %b%b", c, wb0_ready, wb1_ready, !exp1, exp1);
      end
      step();
      if (c == 5) begin
        checks++; if (reg_wr !== 1'b1 || waddr !== 5'd2 || wdata !== 32'h2222_2222) begin
          errors++; $display("FAIL starve_write got %b/%0d/%h want 1/2/22222222", reg_wr, waddr, wdata);
        end
      end
    end
  endtask

  task automatic test_scoreboard();
    do_reset();
    alloc_valid = 1'b1; alloc_addr = 5'd7;
    #1;
    checks++; if (alloc_ready !== 1'b1) begin errors++; $display("FAIL sb_first_alloc_ready got %b want 1", alloc_ready); end
    step();
    checks++; if (busy !== 32'h0000_0080) begin errors++; $display("FAIL sb_set got %h want 00000080", busy); end
    #1;
    checks++; if (alloc_ready !== 1'b0) begin errors++; $display("FAIL sb_second_alloc_ready got %b want 0", alloc_ready); end
    step();
    checks++; if (busy !== 32'h0000_0080) begin errors++; $display("FAIL sb_hold got %h want 00000080", busy); end
    wb1_valid = 1'b1; wb1_addr = 5'd7; wb1_data = 32'h0000_7777;
    #1;
    checks++; if (wb1_ready !== 1'b1 || alloc_ready !== 1'b1) begin
      errors++; $display("FAIL sb_same_cycle_ready got wb1 %b alloc %b want 1 1", wb1_ready, alloc_ready);
    end
    step();
    checks++; if (busy !== 32'h0000_0080) begin errors++; $display("FAIL sb_set_wins got %h want 00000080", busy); end
    checks++; if (reg_wr !== 1'b1 || waddr !== 5'd7 || wdata !== 32'h0000_7777) begin
      errors++; $display("FAIL sb_wb1_write got %b/%0d/%h want 1/7/00007777", reg_wr, waddr, wdata);
    end
    alloc_valid = 1'b0;
    step();
    checks++; if (busy !== 32'h0) begin errors++; $display("FAIL sb_clear got %h want 00000000", busy); end
    wb1_addr = 5'd9;
    alloc_valid = 1'b1; alloc_addr = 5'd3;
    wb0_valid = 1'b0;
    step();
    checks++; if (busy !== 32'h0000_0008) begin errors++; $display("FAIL sb_clear_unset got %h want 00000008", busy); end
    wb1_valid = 1'b0; alloc_valid = 1'b0;
    wb0_valid = 1'b1; wb0_addr = 5'd3; wb0_data = 32'h3;
    step();
    checks++; if (busy !== 32'h0000_0008) begin errors++; $display("FAIL sb_wb0_no_touch got %h want 00000008", busy); end
  endtask

  task automatic test_x0();
    do_reset();
    wb0_valid = 1'b1; wb0_addr = 5'd0; wb0_data = 32'hFFFF_FFFF;
    alloc_valid = 1'b1; alloc_addr = 5'd0;
    #1;
    checks++; if (wb0_ready !== 1'b1) begin errors++; $display("FAIL x0_ready got %b want 1", wb0_ready); end
    checks++; if (alloc_ready !== 1'b1) begin errors++; $display("FAIL x0_alloc_ready got %b want 1", alloc_ready); end
    step();
    checks++; if (reg_wr !== 1'b0 || waddr !== 5'd0 || wdata !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL x0_write got %b/%0d/%h want 0/0/ffffffff", reg_wr, waddr, wdata);
    end
    checks++; if (busy !== 32'h0) begin errors++; $display("FAIL x0_busy got %h want 00000000", busy); end
  endtask

  task automatic test_back_to_back();
    logic [4:0]  a;
    logic [31:0] d;
    do_reset();
    wb1_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a = 5'(10 + i);
      d = 32'hC0DE_0000 + 32'(i);
      wb1_addr = a; wb1_data = d;
      step();
      checks++; if (reg_wr !== 1'b1 || waddr !== a || wdata !== d) begin
        errors++; $display("FAIL b2b_write %0d got %b/%0d/%h want 1/%0d/%h", i, reg_wr, waddr, wdata, a, d);
      end
    end
    wb1_valid = 1'b0; wb1_addr = 5'd31; wb1_data = 32'hDEAD_BEEF;
    step();
    checks++; if (reg_wr !== 1'b0 || waddr !== 5'd12 || wdata !== 32'hC0DE_0002) begin
      errors++; $display("FAIL idle_hold got %b/%0d/%h want 0/12/c0de0002", reg_wr, waddr, wdata);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    wb0_valid = 1'b1; wb0_addr = 5'd8; wb0_data = 32'h8888_8888;
    alloc_valid = 1'b1; alloc_addr = 5'd4;
    step();
    checks++; if (reg_wr !== 1'b1 || busy !== 32'h0000_0010) begin
      errors++; $display("FAIL async_pre got %b/%h want 1/00000010", reg_wr, busy);
    end
    #1;
    reset = 1'b0;
    #1;
    checks++; if (reg_wr !== 1'b0 || waddr !== 5'd0 || busy !== 32'h0) begin
      errors++; $display("FAIL async_reset got %b/%0d/%h want 0/0/00000000", reg_wr, waddr, busy);
    end
    step();
    reset = 1'b1;
  endtask

`ifdef WB_RR_EN
  task automatic test_round_robin();
    logic exp1;
    do_reset();
    wb0_valid = 1'b1; wb0_addr = 5'd1; wb0_data = 32'h1;
    wb1_valid = 1'b1; wb1_addr = 5'd2; wb1_data = 32'h2;
    for (int c = 0; c < 6; c++) begin
      exp1 = (c % 2 == 1);
      #1;
      checks++; if (wb0_ready !== !exp1 || wb1_ready !== exp1) begin
        errors++; $display("FAIL rr_grant cycle %0d got %b%b want %b%b", c, wb0_ready, wb1_ready, !exp1, exp1);
      end
      step();
    end
  endtask
`endif

  initial begin
    test_reset();
    test_contention();
    test_starvation();
    test_scoreboard();
    test_x0();
    test_back_to_back();
    test_async_reset();
`ifdef WB_RR_EN
    test_round_robin();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-port arbiter and pending-write scoreboard for the 32×32 register file. Two producers share the file's single write port: the single-cycle execute path (requester 0) and a long-latency unit such as a load/multiply engine (requester 1). The block grants one write per cycle with a valid/ready handshake and registers the winning write onto the file's write port. It tracks which destination registers have an outstanding long-latency write so the hazard logic can stall readers.

## Interface
Parameters:
- STARVE_LIMIT, 4: consecutive cycles requester 1 may be refused before it takes priority.

Ports:
- clock  in  1  sole clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low; clears all state immediately.
- wb0_valid / wb1_valid  in  1  requester 0 / 1 presents a write.
- wb0_addr / wb1_addr  in  5  destination register.
- wb0_data / wb1_data  in  32  write data.
- wb0_ready / wb1_ready  out  1  combinational grant; the transfer occurs on a posedge where valid && ready.
- alloc_valid  in  1  requester 1 reserves a destination at issue.
- alloc_addr  in  5  register being reserved.
- alloc_ready  out  1  reservation accepted this cycle.
- reg_wr  out  1  register-file write enable.
- waddr  out  5  register-file write address.
- wdata  out  32  register-file write data.
- busy  out  32  bit i set while register i has an outstanding requester-1 write.

## Operation
- Grant: at most one of wb0_ready/wb1_ready is high per cycle. Ready never depends on the other requester's ready.
- Fixed priority: requester 0 wins unless the starvation counter has reached STARVE_LIMIT. In that case requester 1 wins and the counter clears.
- Starvation counter: increments on each cycle wb1_valid && !wb1_ready, saturates at STARVE_LIMIT, and clears on any requester-1 transfer.
- Accepted write with addr != 0: next cycle reg_wr=1 with the transferred waddr and wdata.
- Accepted write with addr == 0: the handshake completes but reg_wr=0 next cycle. waddr and wdata still update.
- No transfer: reg_wr=0, and waddr and wdata hold their previous values.
- Scoreboard set: alloc_valid && alloc_ready && alloc_addr != 0 sets busy[alloc_addr]. A reservation of x0 is accepted and ignored.
- alloc_ready = !busy[alloc_addr] || (wb1 transfer this cycle to the same addr).
- Scoreboard clear: a requester-1 transfer clears busy[wb1_addr].
  - Simultaneous clear and set of the same bit leaves it set.
  - Clearing a bit that is not set is harmless.
- Requester-0 transfers never touch busy.

## Timing
- Reset values: reg_wr=0, waddr=0, wdata=0, busy=0, starvation counter=0. Reset asserted mid-operation discards the in-flight write: reg_wr drops to 0 asynchronously.
- Latency:
  - Handshake at posedge N gives reg_wr/waddr/wdata valid from N through N+1.
  - The register file captures the write at the negedge inside that cycle.
  - busy updates at posedge N.
- Ready paths are combinational from the valid inputs and current state. No combinational path exists from any input to reg_wr, waddr, wdata or busy.
- Throughput: one write per cycle sustained. Back-to-back grants to the same requester are allowed.

## Configuration
- WB_RR_EN defined:
  - Strict round-robin. A 1-bit last-grant pointer toggles on each transfer, and the other requester wins when both are valid.
  - STARVE_LIMIT and the starvation counter are compiled out.
- WB_RR_EN undefined: fixed priority with the starvation counter, as described under Operation.
- Scoreboard and handshake behaviour are identical in both builds.

## Structure
- Shared package regfile_pkg:
  - typedefs reg_addr_t (logic [4:0]) and word_t (logic [31:0]).
  - constant NUM_REGS=32.
  - enum wb_src_e {WB_EXEC, WB_LONG}.
- One sub-module, wb_grant_logic, holds the priority/starvation (or round-robin) state and produces the two ready signals. The top level keeps the output register and the scoreboard.

## Test plan
- Reset: hold reset=0 with both valids high. Expect reg_wr=0, busy=0, and both readys 0 while reset=0. After release, the first cycle grants wb0.
- Contention: wb0 writes x5=0xAAAA_0001 while wb1 writes x6=0x5555_0002 in the same cycle. Expect wb0_ready=1 and wb1_ready=0. Next cycle reg_wr=1, waddr=5, wdata=0xAAAA_0001.
- Starvation (STARVE_LIMIT=4): both valid continuously. Expect wb0 granted for 4 cycles, wb1 granted on the 5th, then the counter restarts.
- Scoreboard hold: alloc x7 gives busy[7]=1. A second alloc of x7 sees alloc_ready=0. A wb1 write to x7 with a same-cycle alloc of x7 gives alloc_ready=1, and busy[7] stays 1.
- x0 handling: wb0 write to x0 with data 0xFFFF_FFFF handshakes with reg_wr=0 next cycle. alloc of x0 leaves busy=0.
- WB_RR_EN build: both valid for 6 cycles. Grants alternate wb0, wb1, wb0, wb1, wb0, wb1.
